// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the
// decode-facing instruction port. master = fetch stage, slave = memory/decode.
interface fetch_stage_if #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned OPC_W   = 3
);
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic [OPC_W-1:0]   opcode;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr, instr_pc, opcode,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr, instr_pc, opcode,
        output instr_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one read at a time to imem and
// buffers returned words in a 2-entry queue presented to decode.
module fetch_stage #(
    parameter int unsigned       INSTR_W  = 16,
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       OPC_W    = 3,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_stage_if.master     bus
);
    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

    state_e             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic               req_valid_q;
    logic [INSTR_W-1:0] data_q [2];
    logic [ADDR_W-1:0]  dpc_q  [2];
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [1:0]         count_q;

    logic       push;
    logic       pop;
    logic [1:0] count_d;
    logic       drop_next;

    always_comb begin
        push    = (state_q == StWait) && bus.imem_rsp_valid && !redirect_valid;
        pop     = (count_q != 2'd0) && bus.instr_ready;
        count_d = count_q + 2'(push) - 2'(pop);
        // A read stays outstanding across a redirect unless its data lands this cycle.
        drop_next = ((state_q == StWait || state_q == StDrop) && !bus.imem_rsp_valid) ||
                    ((state_q == StReq) && bus.imem_req_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                dpc_q[i]  <= '0;
            end
        end else if (redirect_valid) begin
            pc_q        <= redirect_pc;
            req_valid_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            state_q     <= drop_next ? StDrop : StIdle;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= bus.imem_rsp_data;
                dpc_q[wr_ptr_q]  <= pc_q;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;

            unique case (state_q)
                StIdle: begin
                    if (en && count_q < 2'd2) begin
                        state_q     <= StReq;
                        req_valid_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (bus.imem_req_ready) begin
                        state_q     <= StWait;
                        req_valid_q <= 1'b0;
                    end
                end
                StWait: begin
                    if (bus.imem_rsp_valid) begin
                        pc_q <= pc_q + ADDR_W'(1);
                        if (en && count_d < 2'd2) begin
                            state_q     <= StReq;
                            req_valid_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StDrop: begin
                    if (bus.imem_rsp_valid) begin
                        if (en) begin
                            state_q     <= StReq;
                            req_valid_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = (count_q != 2'd0);
    assign bus.instr          = data_q[rd_ptr_q];
    assign bus.instr_pc       = dpc_q[rd_ptr_q];
    assign bus.opcode         = data_q[rd_ptr_q][INSTR_W-1 -: OPC_W];

    // Credit accounting must make a push into a full queue impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count_q == 2'd2));

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.imem_rsp_valid && state_q != StWait && state_q != StDrop));
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory responders, scoreboard queues of
// expected PCs, and monitors comparing every word decode consumes.
module tb_fetch_stage;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned OPC_W   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       en2 = 1'b0;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_pc = 8'h00;

    always #5 clk = ~clk;

    fetch_stage_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W)) bus ();
    fetch_stage_if #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W)) bus2 ();

    fetch_stage #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .bus(bus)
    );

    fetch_stage #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .OPC_W(OPC_W), .RESET_PC(8'hFF)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .redirect_valid(1'b0),
        .redirect_pc(8'h00), .bus(bus2)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cnt = 0;

    task automatic check(input string nm, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [7:0] a);
        return {a ^ 8'hA5, a};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rst_n && bus.imem_req_valid && bus.imem_req_ready) acc_cnt <= acc_cnt + 1;

    // Main memory: configurable latency and request backpressure.
    int         lat = 1;
    logic       mem_ready = 1'b1;
    int         mem_cnt;
    logic [7:0] mem_addr;
    assign bus.imem_req_ready = mem_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cnt            <= 0;
            mem_addr           <= 8'h00;
            bus.imem_rsp_valid <= 1'b0;
            bus.imem_rsp_data  <= 16'h0000;
        end else begin
            bus.imem_rsp_valid <= 1'b0;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                if (lat <= 1) begin
                    bus.imem_rsp_valid <= 1'b1;
                    bus.imem_rsp_data  <= word_of(bus.imem_req_addr);
                end else begin
                    mem_cnt  <= lat - 1;
                    mem_addr <= bus.imem_req_addr;
                end
            end else if (mem_cnt != 0) begin
                mem_cnt <= mem_cnt - 1;
                if (mem_cnt == 1) begin
                    bus.imem_rsp_valid <= 1'b1;
                    bus.imem_rsp_data  <= word_of(mem_addr);
                end
            end
        end
    end

    // Second memory: always ready, 1-cycle latency.
    assign bus2.imem_req_ready = 1'b1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus2.imem_rsp_valid <= 1'b0;
            bus2.imem_rsp_data  <= 16'h0000;
        end else begin
            bus2.imem_rsp_valid <= bus2.imem_req_valid;
            bus2.imem_rsp_data  <= word_of(bus2.imem_req_addr);
        end
    end

    // Scoreboards: decode only consumes while an expectation is pending.
    logic [7:0]  exp_q[$];
    logic [7:0]  exp2_q[$];
    logic        rdy_en = 1'b0;
    logic        rdy2_en = 1'b0;
    logic        gap_chk = 1'b0;
    logic        have_last = 1'b0;
    int          last_pop = 0;
    logic [7:0]  mon_p;
    logic [15:0] mon_w;
    logic [7:0]  mon2_p;
    logic [15:0] mon2_w;

    initial begin
        bus.instr_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.instr_ready = rdy_en && rst_n && (exp_q.size() != 0);
            if (!gap_chk) have_last = 1'b0;
            if (bus.instr_valid && bus.instr_ready) begin
                mon_p = exp_q.pop_front();
                mon_w = word_of(mon_p);
                check("instr_pc", bus.instr_pc, mon_p);
                check("instr", bus.instr, mon_w);
                check("opcode", bus.opcode, mon_w[15:13]);
                if (gap_chk && have_last) check("pop_gap", cyc - last_pop, 2);
                last_pop  = cyc;
                have_last = 1'b1;
            end
        end
    end

    initial begin
        bus2.instr_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus2.instr_ready = rdy2_en && rst_n && (exp2_q.size() != 0);
            if (bus2.instr_valid && bus2.instr_ready) begin
                mon2_p = exp2_q.pop_front();
                mon2_w = word_of(mon2_p);
                check("wrap_instr_pc", bus2.instr_pc, mon2_p);
                check("wrap_instr", bus2.instr, mon2_w);
            end
        end
    end

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(nm, exp_q.size(), 0);
    endtask

    task automatic wait_req(input string nm, input logic need_accept);
        int n = 0;
        while (!(bus.imem_req_valid && (bus.imem_req_ready || !need_accept)) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(nm, bus.imem_req_valid, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, bus.imem_req_valid, 0);
        check({tag, "_instr_valid"}, bus.instr_valid, 0);
        check({tag, "_req_addr"}, bus.imem_req_addr, 8'h00);
        check({tag, "_instr"}, bus.instr, 16'h0000);
        check({tag, "_instr_pc"}, bus.instr_pc, 8'h00);
        check({tag, "_opcode"}, bus.opcode, 3'd0);
    endtask

    int acc_before;

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        check("rst2_req_addr", bus2.imem_req_addr, 8'hFF);
        rst_n = 1'b1;
        @(negedge clk);

        // RESET_PC=0xFF instance wraps to 0x00.
        exp2_q.push_back(8'hFF);
        exp2_q.push_back(8'h00);
        rdy2_en = 1'b1;
        en2     = 1'b1;

        // Streaming: one word every two cycles.
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(i));
        gap_chk = 1'b1;
        rdy_en  = 1'b1;
        en      = 1'b1;
        drain("drain_stream");
        gap_chk = 1'b0;
        for (int n = 0; n < 50 && exp2_q.size() != 0; n++) @(negedge clk);
        check("drain_wrap", exp2_q.size(), 0);

        // Decode stall: queue fills to two and fetch stops.
        rdy_en = 1'b0;
        repeat (5) @(negedge clk);
        acc_before = acc_cnt;
        repeat (5) @(negedge clk);
        check("stall_req_valid", bus.imem_req_valid, 0);
        check("stall_instr_valid", bus.instr_valid, 1);
        check("stall_no_accept", acc_cnt - acc_before, 0);
        for (int i = 6; i < 10; i++) exp_q.push_back(8'(i));
        rdy_en = 1'b1;
        drain("drain_stall");

        // Flush, then redirect while a 3-cycle read is in flight.
        rdy_en = 1'b0;
        en     = 1'b0;
        repeat (6) @(negedge clk);
        redirect_pc    = 8'h20;
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("flush_instr_valid", bus.instr_valid, 0);
        lat = 3;
        en  = 1'b1;
        wait_req("accept_0x20", 1'b1);
        check("addr_0x20", bus.imem_req_addr, 8'h20);
        @(negedge clk);
        redirect_pc    = 8'h40;
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_req("req_after_redirect", 1'b0);
        check("redirect_addr", bus.imem_req_addr, 8'h40);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        rdy_en = 1'b1;
        drain("drain_redirect");

        // Request held under backpressure, en dropped mid-hold.
        rdy_en = 1'b0;
        en     = 1'b0;
        repeat (8) @(negedge clk);
        lat            = 1;
        redirect_pc    = 8'h60;
        redirect_valid = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        mem_ready      = 1'b0;
        en             = 1'b1;
        wait_req("hold_req_seen", 1'b0);
        acc_before = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", bus.imem_req_valid, 1);
            check("hold_addr", bus.imem_req_addr, 8'h60);
            if (i == 1) en = 1'b0;
            @(negedge clk);
        end
        mem_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("single_accept", acc_cnt - acc_before, 1);
        check("idle_after_hold", bus.imem_req_valid, 0);
        exp_q.push_back(8'h60);
        rdy_en = 1'b1;
        drain("drain_hold");

        // Asynchronous reset during an outstanding read.
        rdy_en = 1'b0;
        lat    = 3;
        en     = 1'b1;
        wait_req("accept_pre_reset", 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        wait_req("req_after_reset", 1'b0);
        check("restart_addr", bus.imem_req_addr, 8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        rdy_en = 1'b1;
        drain("drain_restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
